// File: rtl/rvc_asap_5pl_dmem_arb_if.sv
// Shared data-memory port bundle: core requester, external requester and the
// single sync-read memory port behind the arbiter.
interface rvc_asap_5pl_dmem_arb_if;
   logic        CoreReq;
   logic        CoreWr;
   logic [31:0] CoreAddr;
   logic [31:0] CoreData;
   logic [3:0]  CoreByteEn;
   logic        CoreGnt;
   logic        CoreRdValid;
   logic [31:0] CoreRdData;

   logic        ExtReq;
   logic        ExtWr;
   logic        ExtLock;
   logic [31:0] ExtAddr;
   logic [31:0] ExtData;
   logic [3:0]  ExtByteEn;
   logic        ExtGnt;
   logic        ExtRdValid;
   logic [31:0] ExtRdData;

   logic [31:0] address;
   logic [31:0] data;
   logic [3:0]  byteena;
   logic        wren;
   logic        rden;
   logic [31:0] q;

   // Arbiter side
   modport slave (
      input  CoreReq, CoreWr, CoreAddr, CoreData, CoreByteEn,
      output CoreGnt, CoreRdValid, CoreRdData,
      input  ExtReq, ExtWr, ExtLock, ExtAddr, ExtData, ExtByteEn,
      output ExtGnt, ExtRdValid, ExtRdData,
      output address, data, byteena, wren, rden,
      input  q
   );

   // Requesters plus memory side
   modport master (
      output CoreReq, CoreWr, CoreAddr, CoreData, CoreByteEn,
      input  CoreGnt, CoreRdValid, CoreRdData,
      output ExtReq, ExtWr, ExtLock, ExtAddr, ExtData, ExtByteEn,
      input  ExtGnt, ExtRdValid, ExtRdData,
      input  address, data, byteena, wren, rden,
      output q
   );
endinterface

// File: rtl/rvc_asap_5pl_dmem_arb.sv
// Core/external arbiter for the shared data-memory port: core priority with
// starvation-forced and locked-burst external ownership, 1-cycle read return.
module rvc_asap_5pl_dmem_arb #(
   parameter int unsigned STARVE_MAX = 8,
   parameter int unsigned BURST_MAX  = 4
) (
   input logic                    Clock,
   input logic                    Rst,
   rvc_asap_5pl_dmem_arb_if.slave bus
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic {
      ARB_CORE = 1'b0,
      ARB_EXT  = 1'b1
   } arb_state_e;

   arb_state_e       state;
   arb_state_e       state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_nxt;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] beat_nxt;
   logic             core_gnt_c;
   logic             ext_gnt_c;
   logic             rd_pend_core;
   logic             rd_pend_ext;

   // State and counter registers
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state      <= ARB_CORE;
         starve_cnt <= '0;
         beat_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         beat_cnt   <= beat_nxt;
      end
   end

   // Grant decision and ownership transitions
   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      beat_nxt   = beat_cnt;
      core_gnt_c = 1'b0;
      ext_gnt_c  = 1'b0;
      case (state)
         ARB_CORE: begin
            core_gnt_c = Rst && bus.CoreReq;
            ext_gnt_c  = Rst && bus.ExtReq && !bus.CoreReq;
            if (ext_gnt_c || !bus.ExtReq) begin
               starve_nxt = '0;
            end else if (starve_cnt != STARVE_LIM) begin
               starve_nxt = starve_cnt + CNT_ONE;
            end
            // Forced entry fires the cycle the denial streak hits the limit
            if (bus.ExtReq && !ext_gnt_c && (starve_nxt == STARVE_LIM)) begin
               state_nxt = ARB_EXT;
               beat_nxt  = '0;
            end else if (ext_gnt_c && bus.ExtLock && (BURST_LIM > CNT_ONE)) begin
               state_nxt = ARB_EXT;
               beat_nxt  = CNT_ONE;
            end
         end
         ARB_EXT: begin
            ext_gnt_c  = Rst && bus.ExtReq;
            starve_nxt = '0;
            if (ext_gnt_c) begin
               beat_nxt = beat_cnt + CNT_ONE;
            end
            if (!bus.ExtReq || !bus.ExtLock || (beat_nxt == BURST_LIM)) begin
               state_nxt  = ARB_CORE;
               starve_nxt = '0;
               beat_nxt   = '0;
            end
         end
         default: begin
            state_nxt  = ARB_CORE;
            starve_nxt = '0;
            beat_nxt   = '0;
         end
      endcase
   end

   assign bus.CoreGnt = core_gnt_c;
   assign bus.ExtGnt  = ext_gnt_c;

   // Memory port mux; idle port is driven to zero
   always_comb begin
      bus.address = '0;
      bus.data    = '0;
      bus.byteena = '0;
      bus.wren    = 1'b0;
      bus.rden    = 1'b0;
      if (core_gnt_c) begin
         bus.address = bus.CoreAddr;
         bus.data    = bus.CoreData;
         bus.byteena = bus.CoreByteEn;
         bus.wren    = bus.CoreWr;
         bus.rden    = !bus.CoreWr;
      end else if (ext_gnt_c) begin
         bus.address = bus.ExtAddr;
         bus.data    = bus.ExtData;
         bus.byteena = bus.ExtByteEn;
         bus.wren    = bus.ExtWr;
         bus.rden    = !bus.ExtWr;
      end
   end

   // Read-return owner tag, one deep to match the memory latency
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         rd_pend_core <= 1'b0;
         rd_pend_ext  <= 1'b0;
      end else begin
         rd_pend_core <= core_gnt_c && !bus.CoreWr;
         rd_pend_ext  <= ext_gnt_c && !bus.ExtWr;
      end
   end

   assign bus.CoreRdValid = rd_pend_core;
   assign bus.ExtRdValid  = rd_pend_ext;
   assign bus.CoreRdData  = rd_pend_core ? bus.q : '0;
   assign bus.ExtRdData   = rd_pend_ext  ? bus.q : '0;

endmodule
